data_bus_arbiter: RTL and testbench
===================================

Name: data_bus_arbiter

Overview:
- Shares the single data-memory bus between two requesters.
- Port 0 is the core's data-memory interface bus outputs; port 1 is the debug/program-loader port.
- Round-robin arbitration, one transaction outstanding at a time, and a fixed-latency read return path.
- Sits between the core's dmem bus signals and the memory model; the core stalls whenever its gnt is low.

Parameters:
- ADDR_WIDTH, 32, width of address on both requesters and the bus
- DATA_WIDTH, 32, width of write/read data; byte enable is DATA_WIDTH/8
- READ_LATENCY, 1, cycles from bus_read_enable accepted to bus_read_data valid; legal range 1..4

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  requester 0 transaction request; held with its fields until m0_gnt
- m0_write  in  1  1=write, 0=read
- m0_address  in  ADDR_WIDTH  byte address
- m0_write_data  in  DATA_WIDTH  write data
- m0_byte_enable  in  DATA_WIDTH/8  byte lanes
- m0_gnt  out  1  request accepted this cycle
- m0_read_valid  out  1  one-cycle pulse; m0_read_data valid
- m0_read_data  out  DATA_WIDTH  returned read data
- m1_req, m1_write, m1_address, m1_write_data, m1_byte_enable, m1_gnt, m1_read_valid, m1_read_data: same as m0, for requester 1
- bus_address  out  ADDR_WIDTH  to memory
- bus_write_data  out  DATA_WIDTH  to memory
- bus_byte_enable  out  DATA_WIDTH/8  to memory
- bus_read_enable  out  1  read strobe, single cycle
- bus_write_enable  out  1  write strobe, single cycle
- bus_read_data  in  DATA_WIDTH  from memory, sampled READ_LATENCY cycles after the strobe

Behaviour:
- States: IDLE, READ_WAIT.
- Reset:
  - state=IDLE; last_grant=1, so m0 wins the first contention; wait counter=0; read_owner=0.
  - All gnt, read_valid, bus strobes=0; bus_address/write_data/byte_enable=0; read_data regs=0.
  - Reset during READ_WAIT aborts the read; no read_valid is ever produced for it.
- IDLE:
  - If only one req is high, that requester is selected.
  - If both are high, the requester not equal to last_grant is selected.
  - Selection is combinational in the same cycle: gnt=1 for the selected requester, and the bus fields are driven from it.
  - bus_write_enable = sel_write; bus_read_enable = !sel_write. With no req, all bus outputs are 0.
  - last_grant is updated on every grant.
- Write: completes in the grant cycle; stay in IDLE. Back-to-back writes are allowed, one per cycle, alternating under contention.
- Read: on grant, latch read_owner, load counter with READ_LATENCY, go to READ_WAIT.
- READ_WAIT:
  - No gnt and no bus strobes; both reqs are ignored and held.
  - Counter decrements each cycle. At the cycle where it reaches 0, capture bus_read_data into the owner's read_data register and pulse the owner's read_valid for one cycle (the cycle after capture); return to IDLE in that same cycle.
  - A new grant can issue in the same cycle as read_valid (read-to-read gap = READ_LATENCY+1 cycles).
- mX_read_data holds its last value until the next read for that requester.
- Simultaneous req from the requester currently receiving read_valid is legal and arbitrated normally.
- A requester dropping req before gnt is a protocol violation; no recovery is defined, and it is flagged by the bench assertion only.

Optional Feature:
- Macro: DATA_BUS_ARBITER_PERF_COUNTERS_EN.
- Defined: adds outputs m0_grant_count[31:0], m1_grant_count[31:0] and contention_count[31:0].
  - Grant counters increment on each grant.
  - contention_count increments each cycle a req is high without gnt.
  - All three saturate at 0xFFFFFFFF and clear on reset.
- Undefined: ports and counters are absent; arbitration is identical.

Decomposition:
- Shared package: arb_state_e {ARB_IDLE, ARB_READ_WAIT}; the requester-index type; constant ARB_NUM_REQ=2.
- One sub-module: rr_arbiter2, a combinational 2-way round-robin picker (inputs req[1:0] and last_grant; outputs grant one-hot).
- The FSM, latency counter and return path live in the top module.

Test Plan:
- Reset, then m0 write addr 0x100, data 0xDEADBEEF, be 0xF -> m0_gnt=1 and bus_write_enable=1 in the same cycle, bus_address=0x100; next cycle all bus strobes 0.
- m0 and m1 assert writes together for 4 cycles -> grant order m0,m1,m0,m1, one per cycle.
- READ_LATENCY=2; m1 read 0x40, memory returns 0x12345678 -> bus_read_enable 1 cycle, m1_read_valid pulses exactly 3 cycles after gnt with m1_read_data=0x12345678; m0_read_valid stays 0.
- m0 read granted, m1 req raised during READ_WAIT -> m1_gnt only in the cycle m0_read_valid pulses; no bus strobe during the wait.
- reset asserted 1 cycle into READ_WAIT -> no read_valid, state IDLE, next m0 request granted first.
- With DATA_BUS_ARBITER_PERF_COUNTERS_EN, run the 4-cycle contention test -> m0_grant_count=2, m1_grant_count=2, contention_count=4.

Source files
------------

// File: rtl/data_bus_arbiter_pkg.sv
// data_bus_arbiter_pkg: shared state, requester-index types and helpers for the data bus arbiter
package data_bus_arbiter_pkg;
    localparam int ARB_NUM_REQ = 2;
    typedef enum logic [0:0] {ARB_IDLE, ARB_READ_WAIT} arb_state_e;
    typedef logic [$clog2(ARB_NUM_REQ)-1:0] req_idx_t;
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return &v ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/data_bus_arbiter_if.sv
// data_bus_arbiter_if: requester, memory-bus and optional DATA_BUS_ARBITER_PERF_COUNTERS_EN signals of the arbiter
interface data_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    logic                  m0_req, m0_write, m0_gnt, m0_read_valid;
    logic [ADDR_WIDTH-1:0] m0_address;
    logic [DATA_WIDTH-1:0] m0_write_data, m0_read_data;
    logic [BE_WIDTH-1:0]   m0_byte_enable;
    logic                  m1_req, m1_write, m1_gnt, m1_read_valid;
    logic [ADDR_WIDTH-1:0] m1_address;
    logic [DATA_WIDTH-1:0] m1_write_data, m1_read_data;
    logic [BE_WIDTH-1:0]   m1_byte_enable;
    logic [ADDR_WIDTH-1:0] bus_address;
    logic [DATA_WIDTH-1:0] bus_write_data, bus_read_data;
    logic [BE_WIDTH-1:0]   bus_byte_enable;
    logic                  bus_read_enable, bus_write_enable;
`ifdef DATA_BUS_ARBITER_PERF_COUNTERS_EN
    logic [31:0]           m0_grant_count, m1_grant_count, contention_count;
`endif
    modport slave (
        input  m0_req, m0_write, m0_address, m0_write_data, m0_byte_enable,
        input  m1_req, m1_write, m1_address, m1_write_data, m1_byte_enable,
        input  bus_read_data,
        output m0_gnt, m0_read_valid, m0_read_data,
        output m1_gnt, m1_read_valid, m1_read_data,
        output bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable
`ifdef DATA_BUS_ARBITER_PERF_COUNTERS_EN
        , output m0_grant_count, m1_grant_count, contention_count
`endif
    );
    modport master (
        output m0_req, m0_write, m0_address, m0_write_data, m0_byte_enable,
        output m1_req, m1_write, m1_address, m1_write_data, m1_byte_enable,
        output bus_read_data,
        input  m0_gnt, m0_read_valid, m0_read_data,
        input  m1_gnt, m1_read_valid, m1_read_data,
        input  bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable
`ifdef DATA_BUS_ARBITER_PERF_COUNTERS_EN
        , input m0_grant_count, m1_grant_count, contention_count
`endif
    );
endinterface

// File: rtl/data_bus_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin picker, favouring the requester that did not win last
module rr_arbiter2
    import data_bus_arbiter_pkg::*;
(
    input  logic [ARB_NUM_REQ-1:0] req,
    input  req_idx_t               last_grant,
    output logic [ARB_NUM_REQ-1:0] grant
);
    always_comb grant = &req ? (last_grant[0] ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: round-robin sharing of the data bus, fixed-latency reads; DATA_BUS_ARBITER_PERF_COUNTERS_EN adds counters
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input logic              clock,
    input logic              reset,
    data_bus_arbiter_if.slave bus
);
    localparam logic [0:0] IDLE      = ARB_IDLE;
    localparam logic [0:0] READ_WAIT = ARB_READ_WAIT;
    localparam logic [2:0] LATENCY   = 3'(READ_LATENCY);
    logic [0:0]              state;
    logic [2:0]              count;
    req_idx_t                last_grant, read_owner;
    logic [ARB_NUM_REQ-1:0]  req, pick, grant;
    logic                    sel, sel_write, read_valid0, read_valid1;
    logic [ADDR_WIDTH-1:0]   sel_address;
    logic [DATA_WIDTH-1:0]   sel_write_data, read_data0, read_data1;
    logic [DATA_WIDTH/8-1:0] sel_byte_enable;
    assign req = {bus.m1_req, bus.m0_req};
    rr_arbiter2 u_pick (
        .req        (req),
        .last_grant (last_grant),
        .grant      (pick)
    );
    always_comb begin
        grant                = state == IDLE ? pick : '0;
        sel                  = grant[1];
        sel_write            = sel ? bus.m1_write : bus.m0_write;
        sel_address          = sel ? bus.m1_address : bus.m0_address;
        sel_write_data       = sel ? bus.m1_write_data : bus.m0_write_data;
        sel_byte_enable      = sel ? bus.m1_byte_enable : bus.m0_byte_enable;
        bus.m0_gnt           = grant[0];
        bus.m1_gnt           = grant[1];
        bus.bus_write_enable = |grant & sel_write;
        bus.bus_read_enable  = |grant & !sel_write;
        bus.bus_address      = |grant ? sel_address : '0;
        bus.bus_write_data   = |grant ? sel_write_data : '0;
        bus.bus_byte_enable  = |grant ? sel_byte_enable : '0;
        bus.m0_read_valid    = read_valid0;
        bus.m1_read_valid    = read_valid1;
        bus.m0_read_data     = read_data0;
        bus.m1_read_data     = read_data1;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            count       <= '0;
            read_owner  <= '0;
            read_valid0 <= 1'b0;
            read_valid1 <= 1'b0;
            read_data0  <= '0;
            read_data1  <= '0;
        end else begin
            read_valid0 <= 1'b0;
            read_valid1 <= 1'b0;
            if (state == IDLE) begin
                if (|grant) begin
                    last_grant <= sel;
                    if (!sel_write) begin
                        read_owner <= sel;
                        count      <= LATENCY;
                        state      <= READ_WAIT;
                    end
                end
            end else begin
                count <= count - 3'd1;
                // memory data is valid in the cycle the counter steps from 1 to 0
                if (count == 3'd1) begin
                    state <= IDLE;
                    if (read_owner[0]) begin
                        read_data1  <= bus.bus_read_data;
                        read_valid1 <= 1'b1;
                    end else begin
                        read_data0  <= bus.bus_read_data;
                        read_valid0 <= 1'b1;
                    end
                end
            end
        end
    end
`ifdef DATA_BUS_ARBITER_PERF_COUNTERS_EN
    logic [31:0] m0_grants, m1_grants, contentions;
    always_ff @(posedge clock) begin
        if (reset) begin
            m0_grants   <= '0;
            m1_grants   <= '0;
            contentions <= '0;
        end else begin
            m0_grants   <= grant[0] ? sat_inc(m0_grants) : m0_grants;
            m1_grants   <= grant[1] ? sat_inc(m1_grants) : m1_grants;
            contentions <= |(req & ~grant) ? sat_inc(contentions) : contentions;
        end
    end
    assign bus.m0_grant_count   = m0_grants;
    assign bus.m1_grant_count   = m1_grants;
    assign bus.contention_count = contentions;
`endif
endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter: randomized scoreboard bench for data_bus_arbiter against a transaction-level model
module tb_data_bus_arbiter;
    localparam int AW = 32, DW = 32, BW = DW / 8, RL = 2;
    logic clock = 1'b0, reset = 1'b1;
    always #5 clock = ~clock;
    data_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    data_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );
    typedef struct {bit v; logic write; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [BW-1:0] be;} tx_t;
    typedef struct {int cyc; int who; logic write; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [BW-1:0] be;} gexp_t;
    typedef struct {int cyc; int who; logic [DW-1:0] data;} rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];
    gexp_t ge;
    rexp_t re;
    tx_t p[2];
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] model_mem [logic [AW-1:0]];
    logic [DW-1:0] rd_sched [int];
    int total = 0, bad = 0, cyc = 0, free_at = 0, last = 1, gen_prob = 0, exp_cont = 0;
    int exp_gc[2] = '{0, 0};
    bit running = 0, wr_only = 0;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    a_m0_hold: assert property (@(posedge clock) disable iff (reset) bus.m0_req && !bus.m0_gnt |=> bus.m0_req)
        else $error("FAIL protocol: m0 dropped req before gnt");
    a_m1_hold: assert property (@(posedge clock) disable iff (reset) bus.m1_req && !bus.m1_gnt |=> bus.m1_req)
        else $error("FAIL protocol: m1 dropped req before gnt");

    // memory model plus monitor: responds to the bus and pops the scoreboard whenever the DUT presents something
    always @(negedge clock) begin
        if (running && !reset) begin
            if (bus.bus_write_enable) mem[bus.bus_address] = bus.bus_write_data;
            if (bus.bus_read_enable)
                rd_sched[cyc + RL] = mem.exists(bus.bus_address) ? mem[bus.bus_address] : init_word(bus.bus_address);
            if (bus.m0_gnt | bus.m1_gnt | bus.bus_write_enable | bus.bus_read_enable) begin
                if (gq.size() == 0)
                    check("unexpected_grant", {bus.m1_gnt, bus.m0_gnt, bus.bus_write_enable, bus.bus_read_enable}, 0);
                else begin
                    ge = gq.pop_front();
                    check("grant_cycle", 96'(cyc), 96'(ge.cyc));
                    check("grant_onehot", {bus.m1_gnt, bus.m0_gnt}, ge.who == 1 ? 2'b10 : 2'b01);
                    check("bus_strobes", {bus.bus_write_enable, bus.bus_read_enable}, ge.write ? 2'b10 : 2'b01);
                    check("bus_fields", {bus.bus_address, bus.bus_write_data, bus.bus_byte_enable}, {ge.addr, ge.wdata, ge.be});
                end
            end else begin
                if (gq.size() > 0 && gq[0].cyc == cyc) begin
                    check("grant_missing", {bus.m1_gnt, bus.m0_gnt}, gq[0].who == 1 ? 2'b10 : 2'b01);
                    void'(gq.pop_front());
                end
                if (!bus.m0_req && !bus.m1_req)
                    check("idle_bus_zero", {bus.bus_address, bus.bus_write_data, bus.bus_byte_enable}, 0);
            end
            if (bus.m0_read_valid | bus.m1_read_valid) begin
                if (rq.size() == 0)
                    check("unexpected_read_valid", {bus.m1_read_valid, bus.m0_read_valid}, 0);
                else begin
                    re = rq.pop_front();
                    check("read_cycle", 96'(cyc), 96'(re.cyc));
                    check("read_owner", {bus.m1_read_valid, bus.m0_read_valid}, re.who == 1 ? 2'b10 : 2'b01);
                    check("read_data", re.who == 1 ? bus.m1_read_data : bus.m0_read_data, re.data);
                end
            end else if (rq.size() > 0 && rq[0].cyc == cyc) begin
                check("read_valid_missing", {bus.m1_read_valid, bus.m0_read_valid}, rq[0].who == 1 ? 2'b10 : 2'b01);
                void'(rq.pop_front());
            end
        end
    end

    // one bus cycle: refill requesters, drive them, predict the grant, advance to the next cycle
    task automatic do_cycle();
        int w;
        for (int i = 0; i < 2; i++)
            if (!p[i].v && $urandom_range(0, 99) < gen_prob) begin
                p[i].v     = 1'b1;
                p[i].write = wr_only ? 1'b1 : 1'($urandom_range(0, 1));
                p[i].addr  = AW'($urandom_range(0, 15) * 4);
                p[i].wdata = DW'($urandom);
                p[i].be    = BW'($urandom_range(1, 15));
            end
        bus.m0_req = p[0].v; bus.m0_write = p[0].write; bus.m0_address = p[0].addr;
        bus.m0_write_data = p[0].wdata; bus.m0_byte_enable = p[0].be;
        bus.m1_req = p[1].v; bus.m1_write = p[1].write; bus.m1_address = p[1].addr;
        bus.m1_write_data = p[1].wdata; bus.m1_byte_enable = p[1].be;
        bus.bus_read_data = rd_sched.exists(cyc) ? rd_sched[cyc] : DW'($urandom);
        w = -1;
        if (cyc >= free_at) begin
            if (p[0].v && p[1].v) w = 1 - last;
            else if (p[0].v) w = 0;
            else if (p[1].v) w = 1;
        end
        if ((p[0].v && w != 0) || (p[1].v && w != 1)) exp_cont++;
        if (w >= 0) begin
            gq.push_back('{cyc, w, p[w].write, p[w].addr, p[w].wdata, p[w].be});
            last = w;
            exp_gc[w]++;
            if (p[w].write) begin
                model_mem[p[w].addr] = p[w].wdata;
                free_at = cyc + 1;
            end else begin
                rq.push_back('{cyc + RL + 1, w, model_mem.exists(p[w].addr) ? model_mem[p[w].addr] : init_word(p[w].addr)});
                free_at = cyc + RL + 1;
            end
            p[w].v = 1'b0;
        end
        @(posedge clock);
        #1 cyc++;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (p[0].v || p[1].v || cyc < free_at || rq.size() > 0); k++) do_cycle();
    endtask

    initial begin
        p[0] = '{1'b0, 1'b0, '0, '0, '0};
        p[1] = '{1'b0, 1'b0, '0, '0, '0};
        bus.m0_req = 0; bus.m0_write = 0; bus.m0_address = 0; bus.m0_write_data = 0; bus.m0_byte_enable = 0;
        bus.m1_req = 0; bus.m1_write = 0; bus.m1_address = 0; bus.m1_write_data = 0; bus.m1_byte_enable = 0;
        bus.bus_read_data = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_gnt_strobe_valid", {bus.m0_gnt, bus.m1_gnt, bus.bus_write_enable, bus.bus_read_enable,
                                         bus.m0_read_valid, bus.m1_read_valid}, 0);
        check("reset_bus_fields", {bus.bus_address, bus.bus_write_data, bus.bus_byte_enable}, 0);
        check("reset_read_data", {bus.m0_read_data, bus.m1_read_data}, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        running = 1'b1;
        p[0] = '{1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF};
        do_cycle();
        gen_prob = 100; wr_only = 1'b1;
        repeat (4) do_cycle();
        gen_prob = 0; drain();
        p[1] = '{1'b1, 1'b0, 32'h40, '0, 4'hF};
        p[0] = '{1'b1, 1'b0, 32'h44, '0, 4'hF};
        do_cycle();
        drain();
        gen_prob = 55; wr_only = 1'b0;
        repeat (400) do_cycle();
        gen_prob = 0; drain();
        p[0] = '{1'b1, 1'b0, 32'h40, '0, 4'hF};
        do_cycle();
        void'(rq.pop_back());
        reset = 1'b1;
        do_cycle();
        reset = 1'b0;
        check("read_data_after_reset", {bus.m0_read_data, bus.m1_read_data}, 0);
        last = 1; free_at = cyc; exp_cont = 0; exp_gc = '{0, 0};
        gen_prob = 100; wr_only = 1'b1;
        repeat (4) do_cycle();
        gen_prob = 0; drain();
        repeat (RL + 3) do_cycle();
`ifdef DATA_BUS_ARBITER_PERF_COUNTERS_EN
        check("m0_grant_count", bus.m0_grant_count, exp_gc[0]);
        check("m1_grant_count", bus.m1_grant_count, exp_gc[1]);
        check("contention_count", bus.contention_count, exp_cont);
`endif
        running = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
